// File: rtl/stream_join_buffered.sv
// stream_join_buffered
//   Aligns N_INP independent valid/ready producers beat-for-beat. Each input
//   owns a DEPTH-entry circular FIFO, so skewed producers can run ahead. The
//   joined output beat is the concatenation of the head entry of every FIFO.
//   Ready and valid are derived from registered occupancy only (plus flush),
//   so there is no combinational path from oup_ready_i to inp_ready_o.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset (pointers/counts only)
//   flush_i      synchronous clear of every FIFO; gates ready and valid low
//   inp_data_i   N_INP payloads, input i at [i*DATA_WIDTH +: DATA_WIDTH]
//   inp_valid_i  per-input valid
//   inp_ready_o  per-input ready (FIFO not full and no flush)
//   oup_data_o   joined payload, same layout as inp_data_i
//   oup_valid_o  every FIFO non-empty and no flush
//   oup_ready_i  downstream ready
//   pending_o    per-input "FIFO holds at least one entry"
module stream_join_buffered #(
  parameter int N_INP      = 2,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic [N_INP*DATA_WIDTH-1:0] inp_data_i,
  input  logic [N_INP-1:0]            inp_valid_i,
  output logic [N_INP-1:0]            inp_ready_o,
  output logic [N_INP*DATA_WIDTH-1:0] oup_data_o,
  output logic                        oup_valid_o,
  input  logic                        oup_ready_i,
  output logic [N_INP-1:0]            pending_o
);

  if (N_INP < 1) begin : g_bad_n_inp
    $error("stream_join_buffered: N_INP must be >= 1");
  end
  if (DATA_WIDTH < 1) begin : g_bad_data_width
    $error("stream_join_buffered: DATA_WIDTH must be >= 1");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $error("stream_join_buffered: DEPTH must be >= 1");
  end

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  // Payload storage is deliberately left out of reset; only the bookkeeping
  // decides whether an entry is meaningful.
  logic [DATA_WIDTH-1:0] mem_q [N_INP][DEPTH];

  ptr_t wptr_q [N_INP];
  ptr_t wptr_d [N_INP];
  ptr_t rptr_q [N_INP];
  ptr_t rptr_d [N_INP];
  cnt_t cnt_q  [N_INP];
  cnt_t cnt_d  [N_INP];

  logic [N_INP-1:0] nonempty;
  logic [N_INP-1:0] not_full;
  logic [N_INP-1:0] push;
  logic             pop;

  // Explicit wrap at DEPTH-1 so non-power-of-two depths work.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  always_comb begin
    nonempty = '0;
    not_full = '0;
    for (int i = 0; i < N_INP; i++) begin
      nonempty[i] = (cnt_q[i] != '0);
      not_full[i] = (cnt_q[i] != cnt_t'(DEPTH));
    end
  end

  // A full FIFO refuses a beat even in a cycle where it pops; this keeps
  // inp_ready_o independent of oup_ready_i.
  assign inp_ready_o = not_full & {N_INP{!flush_i}};
  assign push        = inp_valid_i & inp_ready_o;
  assign oup_valid_o = (&nonempty) && !flush_i;
  assign pop         = oup_valid_o && oup_ready_i;
  assign pending_o   = nonempty;

  always_comb begin
    oup_data_o = '0;
    for (int i = 0; i < N_INP; i++) begin
      oup_data_o[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[i][rptr_q[i]];
    end
  end

  always_comb begin
    for (int i = 0; i < N_INP; i++) begin
      wptr_d[i] = wptr_q[i];
      rptr_d[i] = rptr_q[i];
      cnt_d[i]  = cnt_q[i];
      if (flush_i) begin
        wptr_d[i] = '0;
        rptr_d[i] = '0;
        cnt_d[i]  = '0;
      end else begin
        if (push[i]) wptr_d[i] = ptr_inc(wptr_q[i]);
        if (pop)     rptr_d[i] = ptr_inc(rptr_q[i]);
        case ({push[i], pop})
          2'b10:   cnt_d[i] = cnt_q[i] + cnt_t'(1);
          2'b01:   cnt_d[i] = cnt_q[i] - cnt_t'(1);
          default: cnt_d[i] = cnt_q[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_INP; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_INP; i++) begin
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < N_INP; i++) begin
      if (push[i]) mem_q[i][wptr_q[i]] <= inp_data_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifndef SYNTHESIS
  a_data_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (oup_valid_o && !oup_ready_i) |=> $stable(oup_data_o))
    else $error("stream_join_buffered: oup_data_o changed while stalled");

  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    pop |-> (&nonempty))
    else $error("stream_join_buffered: pop from an empty FIFO");

  for (genvar g = 0; g < N_INP; g++) begin : g_ovf_chk
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      push[g] |-> (cnt_q[g] != cnt_t'(DEPTH)))
      else $error("stream_join_buffered: push into a full FIFO");
  end
`endif

endmodule

// File: tb/tb_stream_join_buffered.sv
module tb_stream_join_buffered;

  logic clk = 1'b0;
  logic rst_n;

  // instance with DEPTH=2 for directed steps
  logic [15:0] a_data;
  logic [1:0]  a_valid;
  logic        a_flush;
  logic        a_oready;
  logic [1:0]  a_iready;
  logic [15:0] a_odata;
  logic        a_ovalid;
  logic [1:0]  a_pend;

  // instance with DEPTH=3 for the randomized wrap-around run
  logic [15:0] b_data;
  logic [1:0]  b_valid;
  logic        b_flush;
  logic        b_oready;
  logic [1:0]  b_iready;
  logic [15:0] b_odata;
  logic        b_ovalid;
  logic [1:0]  b_pend;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_join_buffered #(.N_INP(2), .DATA_WIDTH(8), .DEPTH(2)) u_d2 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (a_flush),
    .inp_data_i  (a_data),
    .inp_valid_i (a_valid),
    .inp_ready_o (a_iready),
    .oup_data_o  (a_odata),
    .oup_valid_o (a_ovalid),
    .oup_ready_i (a_oready),
    .pending_o   (a_pend)
  );

  stream_join_buffered #(.N_INP(2), .DATA_WIDTH(8), .DEPTH(3)) u_d3 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .flush_i     (b_flush),
    .inp_data_i  (b_data),
    .inp_valid_i (b_valid),
    .inp_ready_o (b_iready),
    .oup_data_o  (b_odata),
    .oup_valid_o (b_ovalid),
    .oup_ready_i (b_oready),
    .pending_o   (b_pend)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Reference model for the random run: per-input push counts and one shared
  // pop count; occupancy = pushed - popped, joined beat k = {src1[k], src0[k]}.
  int          pushed [2];
  int          popped;
  int          cyc;
  logic [7:0]  src [2][10];
  logic [1:0]  ex_rdy;
  logic [1:0]  ex_pend;
  logic        ex_v;

  initial begin
    rst_n    = 1'b0;
    a_data   = '0;
    a_valid  = '0;
    a_flush  = 1'b0;
    a_oready = 1'b1;
    b_data   = '0;
    b_valid  = '0;
    b_flush  = 1'b0;
    b_oready = 1'b0;

    // ---------------- reset state
    @(negedge clk);
    chk("rst_ovalid", a_ovalid, 1'b0);
    chk("rst_pend", a_pend, 2'b00);
    chk("rst_iready", a_iready, 2'b11);
    chk("rst_ovalid_d3", b_ovalid, 1'b0);
    chk("rst_iready_d3", b_iready, 2'b11);
    step();
    rst_n = 1'b1;

    // ---------------- balanced stream
    a_valid = 2'b11; a_data = 16'hA111;
    @(negedge clk);
    chk("bal_iready", a_iready, 2'b11);
    chk("bal_v0", a_ovalid, 1'b0);
    step(); a_data = 16'hA212;
    @(negedge clk);
    chk("bal_v1", a_ovalid, 1'b1);
    chk("bal_d1", a_odata, 16'hA111);
    step(); a_data = 16'hA313;
    @(negedge clk);
    chk("bal_v2", a_ovalid, 1'b1);
    chk("bal_d2", a_odata, 16'hA212);
    chk("bal_iready2", a_iready, 2'b11);
    step(); a_valid = 2'b00;
    @(negedge clk);
    chk("bal_v3", a_ovalid, 1'b1);
    chk("bal_d3", a_odata, 16'hA313);
    step();
    @(negedge clk);
    chk("bal_empty_v", a_ovalid, 1'b0);
    chk("bal_empty_p", a_pend, 2'b00);

    // ---------------- skew
    step();
    a_valid = 2'b01; a_data = 16'h0001;
    step(); a_data = 16'h0002;
    step(); a_valid = 2'b00;
    repeat (3) begin
      @(negedge clk);
      chk("skew_wait_v", a_ovalid, 1'b0);
      chk("skew_wait_p", a_pend, 2'b01);
      step();
    end
    a_valid = 2'b10; a_data = 16'hB000;
    @(negedge clk);
    chk("skew_pre_v", a_ovalid, 1'b0);
    chk("skew_full_rdy", a_iready, 2'b10);
    step(); a_data = 16'hB100;
    @(negedge clk);
    chk("skew_v1", a_ovalid, 1'b1);
    chk("skew_d1", a_odata, 16'hB001);
    step(); a_valid = 2'b00;
    @(negedge clk);
    chk("skew_v2", a_ovalid, 1'b1);
    chk("skew_d2", a_odata, 16'hB102);
    step();
    @(negedge clk);
    chk("skew_end_v", a_ovalid, 1'b0);
    chk("skew_end_p", a_pend, 2'b00);

    // ---------------- full / backpressure
    step();
    a_valid = 2'b01; a_data = 16'h0021;
    step(); a_data = 16'h0022;
    step(); a_data = 16'h0023;
    @(negedge clk);
    chk("full_rdy0", a_iready[0], 1'b0);
    chk("full_pend", a_pend, 2'b01);
    chk("full_v", a_ovalid, 1'b0);
    step();
    @(negedge clk);
    chk("full_hold", a_iready[0], 1'b0);
    step();
    a_oready = 1'b0; a_valid = 2'b11; a_data = 16'hC123;
    @(negedge clk);
    chk("bp_rdyA", a_iready, 2'b10);
    chk("bp_vA", a_ovalid, 1'b0);
    step(); a_data = 16'hC223;
    @(negedge clk);
    chk("bp_vB", a_ovalid, 1'b1);
    chk("bp_dB", a_odata, 16'hC121);
    chk("bp_rdyB", a_iready, 2'b10);
    step(); a_valid = 2'b01;
    @(negedge clk);
    chk("bp_vC", a_ovalid, 1'b1);
    chk("bp_dC", a_odata, 16'hC121);
    chk("bp_rdyC", a_iready, 2'b00);
    step(); a_oready = 1'b1;
    @(negedge clk);
    chk("bp_vD", a_ovalid, 1'b1);
    chk("bp_dD", a_odata, 16'hC121);
    chk("bp_rdyD", a_iready, 2'b00);
    step();
    @(negedge clk);
    chk("bp_dE", a_odata, 16'hC222);
    chk("bp_rdyE", a_iready, 2'b11);
    step(); a_valid = 2'b10; a_data = 16'hC300;
    @(negedge clk);
    chk("bp_vF", a_ovalid, 1'b0);
    chk("bp_pF", a_pend, 2'b01);
    step(); a_valid = 2'b00;
    @(negedge clk);
    chk("bp_dG", a_odata, 16'hC323);
    chk("bp_vG", a_ovalid, 1'b1);
    step();
    @(negedge clk);
    chk("bp_end_v", a_ovalid, 1'b0);
    chk("bp_end_p", a_pend, 2'b00);

    // ---------------- flush
    a_valid = 2'b11; a_data = 16'hD131;
    step(); a_valid = 2'b00; a_flush = 1'b1;
    @(negedge clk);
    chk("fl_v", a_ovalid, 1'b0);
    chk("fl_rdy", a_iready, 2'b00);
    chk("fl_pend", a_pend, 2'b11);
    step(); a_flush = 1'b0;
    @(negedge clk);
    chk("fl_after_v", a_ovalid, 1'b0);
    chk("fl_after_p", a_pend, 2'b00);
    chk("fl_after_rdy", a_iready, 2'b11);
    a_valid = 2'b11; a_data = 16'hE141;
    step(); a_valid = 2'b00;
    @(negedge clk);
    chk("fl_fresh_v", a_ovalid, 1'b1);
    chk("fl_fresh_d", a_odata, 16'hE141);
    step();

    // ---------------- async reset mid-stream
    a_oready = 1'b0; a_valid = 2'b11; a_data = 16'hF151;
    step(); a_valid = 2'b00;
    @(negedge clk);
    chk("ar_pre_v", a_ovalid, 1'b1);
    chk("ar_pre_d", a_odata, 16'hF151);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_v", a_ovalid, 1'b0);
    chk("ar_p", a_pend, 2'b00);
    chk("ar_rdy", a_iready, 2'b11);
    step();
    rst_n = 1'b1;
    a_valid = 2'b11; a_data = 16'hF262; a_oready = 1'b1;
    @(negedge clk);
    chk("ar_rel_rdy", a_iready, 2'b11);
    chk("ar_rel_v", a_ovalid, 1'b0);
    step(); a_valid = 2'b00;
    @(negedge clk);
    chk("ar_new_v", a_ovalid, 1'b1);
    chk("ar_new_d", a_odata, 16'hF262);
    step();
    @(negedge clk);
    chk("ar_end_v", a_ovalid, 1'b0);

    // ---------------- randomized wrap-around on DEPTH=3
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 10; k++) src[i][k] = 8'($urandom);
    pushed[0] = 0; pushed[1] = 0; popped = 0; cyc = 0;
    step();
    while (popped < 10 && cyc < 400) begin
      for (int i = 0; i < 2; i++) begin
        b_valid[i] = (pushed[i] < 10) && ($urandom_range(0, 3) != 0);
        b_data[i*8 +: 8] = (pushed[i] < 10) ? src[i][pushed[i]] : 8'($urandom);
      end
      b_oready = (cyc % 2 == 1);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        ex_rdy[i]  = (pushed[i] - popped) < 3;
        ex_pend[i] = pushed[i] > popped;
      end
      ex_v = ex_pend[0] && ex_pend[1];
      chk("rnd_iready", b_iready, ex_rdy);
      chk("rnd_valid", b_ovalid, ex_v);
      chk("rnd_pend", b_pend, ex_pend);
      if (ex_v) chk("rnd_data", b_odata, {src[1][popped], src[0][popped]});
      step();
      if (ex_v && b_oready) popped++;
      for (int i = 0; i < 2; i++)
        if (b_valid[i] && ex_rdy[i]) pushed[i]++;
      cyc++;
    end
    b_valid = 2'b00;
    chk("rnd_done", popped, 10);
    @(negedge clk);
    chk("rnd_end_v", b_ovalid, 1'b0);
    chk("rnd_end_p", b_pend, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
